microcode_sequencer: RTL
========================

# microcode_sequencer

Next-address controller for the 65C02 microcode ROM. It takes the sequencer field of the current registered microword, together with condition flags, the opcode register and the interrupt request, and produces the 9-bit ROM address for the next microinstruction. It holds the microprogram counter, a small call/return stack and the boot/halt control state. It sits between the ROM data output and the ROM address input, and shares the ROM's clock enable.

## Interface
- AW, 9: microcode address width.
- DEPTH, 4: call-stack entries.
- RESET_ADDR, 9'h1F8: first microinstruction fetched after reset.
- IRQ_ADDR, 9'h1F0: interrupt entry microroutine.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  advance strobe; same signal as the ROM enable
- seq  in  16  sequencer field of the current microword: op[15:12], csel[11:9], target[8:0]
- cond  in  8  condition flags; cond[csel] is tested
- ir  in  8  opcode register
- irq_req  in  1  interrupt pending (already masked by the CPU)
- addr  out  AW  next ROM address (combinational)
- irq_ack  out  1  one-cycle pulse when an interrupt is taken
- fault  out  1  sticky stack over/underflow
- depth  out  $clog2(DEPTH+1)  stack occupancy

## Operation
- State machine states:
  - BOOT: entered on reset. In the first enabled cycle after reset, addr = RESET_ADDR regardless of seq, then the state moves to RUN.
  - RUN: normal sequencing.
  - HALT: entered on a stack fault. addr = upc (the current word is re-fetched). Leaves HALT only on reset.
- upc register: on every enabled edge, upc <= addr. Increment is upc+1 mod 2^AW, so 9'h1FF wraps to 9'h000.
- Ops in RUN:
  - NEXT=0: upc+1.
  - JUMP=1: target.
  - DISP=2: if irq_req, IRQ_ADDR and irq_ack=1; else {1'b0, ir}.
  - CALL=3: push upc+1, then target.
  - RET=4: pop top of stack.
  - BRT=5: target if cond[csel], else upc+1.
  - BRF=6: target if !cond[csel], else upc+1.
  - 7–15: reserved, decoded as NEXT.
- Stack faults:
  - CALL with depth==DEPTH: no push, addr = upc, fault<=1, go to HALT.
  - RET with depth==0: same behaviour.
- irq_ack is asserted only when enable=1, the state is RUN and op=DISP.
- enable=0: upc, stack, depth and state are frozen; irq_ack=0; addr is stable given stable inputs.
- Reset (takes effect regardless of enable; applies mid-routine too):
  - upc=RESET_ADDR, depth=0, fault=0, state=BOOT.
  - Outputs during reset: addr=RESET_ADDR, irq_ack=0, fault=0, depth=0.
  - Stack contents are discarded.

## Timing
- One microinstruction per enabled cycle.
- addr presented in cycle n is clocked into the ROM at the end of n; its seq field is visible in n+1.
- addr, irq_ack: combinational from seq, cond, ir, irq_req, upc, top of stack and state.
- Registered on the enabled edge: upc, stack push/pop, depth, state, fault.
- No combinational path from addr back to seq; the ROM output register breaks the loop.
- A CALL and the target's first word are on consecutive enabled cycles. A RET returns to the pushed address in the next cycle.
- fault rises on the edge following the offending op.

## Structure
- Package microseq_pkg holds:
  - op encodings (OP_NEXT … OP_BRF);
  - seq field width and bit positions;
  - the packed seq-field struct;
  - state enum {BOOT, RUN, HALT}.
- Sub-module microseq_stack: DEPTH x AW LIFO with push, pop, full, empty and top outputs, and a synchronous clear driven by reset.
- Top level: next-address mux, condition mux, FSM and upc register.

## Test plan
- Reset, then enable -> addr=9'h1F8 in the BOOT cycle. With seq=NEXT, the following addrs are 9'h1F9 and 9'h1FA.
- upc=9'h1FF with NEXT -> addr=9'h000. With enable held low for 3 cycles -> addr and upc are unchanged and irq_ack=0.
- DISP with ir=8'hA9, irq_req=0 -> addr=9'h0A9, irq_ack=0. DISP with irq_req=1 -> addr=9'h1F0 and irq_ack high for exactly one cycle.
- CALL 9'h040 at upc=9'h010, then a nested CALL 9'h080 at 9'h041, then RET, RET -> return addresses 9'h042 then 9'h011, depth 0→1→2→1→0.
- DEPTH+1 nested CALLs -> fault=1 and state HALT, addr frozen at upc. A RET with an empty stack also faults. Reset clears both.
- BRT/BRF with csel=3, cond=8'h08 vs 8'h00, target 9'h120 at upc=9'h050:
  - cond=8'h08: BRT -> 9'h120, BRF -> 9'h051.
  - cond=8'h00: BRT -> 9'h051, BRF -> 9'h120.

Source files
------------

// File: rtl/microseq_pkg.sv
// Shared definitions for the microcode next-address sequencer: op codes,
// sequencer-field layout and the control state encoding.
package microseq_pkg;

   localparam int SEQ_W    = 16;
   localparam int OP_LSB   = 12;
   localparam int CSEL_LSB = 9;
   localparam int TARGET_W = 9;

   localparam logic [3:0] OP_NEXT = 4'd0;
   localparam logic [3:0] OP_JUMP = 4'd1;
   localparam logic [3:0] OP_DISP = 4'd2;
   localparam logic [3:0] OP_CALL = 4'd3;
   localparam logic [3:0] OP_RET  = 4'd4;
   localparam logic [3:0] OP_BRT  = 4'd5;
   localparam logic [3:0] OP_BRF  = 4'd6;

   typedef struct packed {
      logic [3:0]          op;
      logic [2:0]          csel;
      logic [TARGET_W-1:0] target;
   } seq_t;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO for microroutine calls; clear empties it in one edge.
module microseq_stack #(
   parameter int AW    = 9,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         clear,
   input  logic                         push,
   input  logic                         pop,
   input  logic [AW-1:0]                data,
   output logic [AW-1:0]                top,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] mem [DEPTH];
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;
   logic [CW-1:0] below;

   assign below  = count - CW'(1);
   assign wr_idx = IW'(count);
   assign rd_idx = IW'(below);
   assign top    = mem[rd_idx];
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (push && !full) begin
         mem[wr_idx] <= data;
         count       <= count + CW'(1);
      end else if (pop && !empty) begin
         count <= below;
      end
   end

endmodule

// File: rtl/microcode_sequencer.sv
// Next-address controller for the microcode ROM: upc register, branch/dispatch
// mux, call stack and BOOT/RUN/HALT control. Advances only when enable is high.
module microcode_sequencer
   import microseq_pkg::*;
#(
   parameter int            AW         = 9,
   parameter int            DEPTH      = 4,
   parameter logic [AW-1:0] RESET_ADDR = 9'h1F8,
   parameter logic [AW-1:0] IRQ_ADDR   = 9'h1F0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [SEQ_W-1:0]            seq,
   input  logic [7:0]                  cond,
   input  logic [7:0]                  ir,
   input  logic                        irq_req,
   output logic [AW-1:0]               addr,
   output logic                        irq_ack,
   output logic                        fault,
   output logic [$clog2(DEPTH+1)-1:0]  depth,
   output state_t                      state
);

   seq_t          f;
   state_t        state_q;
   state_t        state_nxt;
   logic [AW-1:0] upc;
   logic [AW-1:0] upc_inc;
   logic [AW-1:0] target;
   logic [AW-1:0] stack_top;
   logic          stack_full;
   logic          stack_empty;
   logic          push_req;
   logic          pop_req;
   logic          fault_set;
   logic          fault_q;
   logic          cond_bit;
   logic [$clog2(DEPTH+1)-1:0] stack_count;

   assign f        = seq_t'(seq);
   assign upc_inc  = upc + AW'(1);
   assign target   = AW'(f.target);
   assign cond_bit = cond[f.csel];

   microseq_stack #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk   (clk),
      .clear (reset),
      .push  (push_req && enable),
      .pop   (pop_req && enable),
      .data  (upc_inc),
      .top   (stack_top),
      .full  (stack_full),
      .empty (stack_empty),
      .count (stack_count)
   );

   // Stack faults re-fetch the current word and park the sequencer in HALT.
   always_comb begin
      addr      = upc;
      irq_ack   = 1'b0;
      push_req  = 1'b0;
      pop_req   = 1'b0;
      fault_set = 1'b0;
      state_nxt = state_q;
      if (reset) begin
         addr = RESET_ADDR;
      end else begin
         case (state_q)
            BOOT: begin
               addr = RESET_ADDR;
               if (enable) state_nxt = RUN;
            end
            RUN: begin
               case (f.op)
                  OP_JUMP: addr = target;
                  OP_DISP: begin
                     if (irq_req) begin
                        addr    = IRQ_ADDR;
                        irq_ack = enable;
                     end else begin
                        addr = AW'(ir);
                     end
                  end
                  OP_CALL: begin
                     if (stack_full) begin
                        addr      = upc;
                        fault_set = 1'b1;
                        state_nxt = HALT;
                     end else begin
                        addr     = target;
                        push_req = 1'b1;
                     end
                  end
                  OP_RET: begin
                     if (stack_empty) begin
                        addr      = upc;
                        fault_set = 1'b1;
                        state_nxt = HALT;
                     end else begin
                        addr    = stack_top;
                        pop_req = 1'b1;
                     end
                  end
                  OP_BRT:  addr = cond_bit ? target : upc_inc;
                  OP_BRF:  addr = cond_bit ? upc_inc : target;
                  default: addr = upc_inc;
               endcase
            end
            default: addr = upc;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         upc     <= RESET_ADDR;
         state_q <= BOOT;
         fault_q <= 1'b0;
      end else if (enable) begin
         upc     <= addr;
         state_q <= state_nxt;
         if (fault_set) fault_q <= 1'b1;
      end
   end

   assign fault = fault_q && !reset;
   assign depth = reset ? '0 : stack_count;
   assign state = state_q;

endmodule
